// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// using a single full-subtractor cell and one borrow flop.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last_bit;
    logic             d;
    logic             br_next;

    // Next-state decode and the single full-subtractor cell
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_bit   = (cnt == CW'(WIDTH - 1));
        d          = areg[0] ^ breg[0] ^ br;
        br_next    = (~areg[0] & breg[0]) | (~(areg[0] ^ breg[0]) & br);
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On the last bit the operand registers have shifted WIDTH-1 times, so
    // areg[0]/breg[0] hold the original sign bits used for overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            areg <= '0;
            breg <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            areg <= a;
            breg <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            areg <= areg >> 1;
            breg <= breg >> 1;
            br   <= br_next;
            res  <= {d, res[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                diff <= {d, res[WIDTH-1:1]};
                bout <= br_next;
                ovf  <= (areg[0] != breg[0]) && (d != areg[0]);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
